// File: rtl/stack_cpu_controller_if.sv
// Control bus between the stack-machine controller (master) and its datapath (slave).
// Carries the IR opcode and zero flag in, and every strobe and mux select out.
interface stack_cpu_controller_if;
    logic [2:0] opc;
    logic       zero;
    logic       pcWriteUnCond;
    logic       pcWriteCond;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       MtoS;
    logic       push;
    logic       pop;
    logic       tos;
    logic       ldA;
    logic       ldB;
    logic       srcA;
    logic       srcB;
    logic       pcSrc;
    logic [1:0] aluOp;
    logic       fetchStart;

    modport master (
        input  opc, zero,
        output pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite,
               MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, aluOp, fetchStart
    );

    modport slave (
        output opc, zero,
        input  pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite,
               MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, aluOp, fetchStart
    );
endinterface

// File: rtl/stack_cpu_controller.sv
// Multicycle Moore control FSM for the stack-machine datapath.
// Optional INSTR_COUNT_EN adds instrCount/cycleCount outputs.
module stack_cpu_controller (
    input  logic clk,
    input  logic rst,
    stack_cpu_controller_if.master bus
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0] instrCount,
    output logic [15:0] cycleCount
`endif
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        POPA   = 4'd2,
        POPB   = 4'd3,
        EXEC   = 4'd4,
        PUSHR  = 4'd5,
        MEMRD  = 4'd6,
        PUSHM  = 4'd7,
        MEMWR  = 4'd8,
        JMP    = 4'd9,
        JZ     = 4'd10
    } stateT;

    typedef struct packed {
        logic       pcWriteUnCond;
        logic       pcWriteCond;
        logic       IorD;
        logic       memRead;
        logic       memWrite;
        logic       IRWrite;
        logic       MtoS;
        logic       push;
        logic       pop;
        logic       tos;
        logic       ldA;
        logic       ldB;
        logic       srcA;
        logic       srcB;
        logic       pcSrc;
        logic [1:0] aluOp;
        logic       fetchStart;
    } ctrlT;

    localparam ctrlT FETCH_CTRL = '{pcWriteUnCond: 1'b1, memRead: 1'b1, IRWrite: 1'b1,
                                    fetchStart: 1'b1, default: '0};

    function automatic ctrlT decodeCtrl(input stateT s, input logic [2:0] op);
        ctrlT c;
        c = '0;
        case (s)
            FETCH:  c = FETCH_CTRL;
            DECODE: c.tos = 1'b1;
            POPA:   begin c.pop = 1'b1; c.ldA = 1'b1; end
            POPB:   begin c.pop = 1'b1; c.ldB = 1'b1; end
            EXEC: begin
                c.srcA = 1'b1;
                c.srcB = 1'b1;
                case (op)
                    OP_SUB:  c.aluOp = 2'b01;
                    OP_AND:  c.aluOp = 2'b10;
                    OP_NOT:  c.aluOp = 2'b11;
                    default: c.aluOp = 2'b00;
                endcase
            end
            PUSHR:  c.push = 1'b1;
            MEMRD:  begin c.IorD = 1'b1; c.memRead = 1'b1; end
            PUSHM:  begin c.MtoS = 1'b1; c.push = 1'b1; end
            MEMWR:  begin c.IorD = 1'b1; c.memWrite = 1'b1; end
            JMP:    begin c.pcSrc = 1'b1; c.pcWriteUnCond = 1'b1; end
            JZ:     begin c.pcSrc = 1'b1; c.pcWriteCond = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    stateT stateReg;
    stateT stateNext;
    ctrlT  ctrlReg;
    ctrlT  ctrlOut;

    always_comb begin
        stateNext = FETCH;
        case (stateReg)
            FETCH: stateNext = DECODE;
            DECODE: begin
                case (bus.opc)
                    OP_PUSH: stateNext = MEMRD;
                    OP_JMP:  stateNext = JMP;
                    OP_JZ:   stateNext = JZ;
                    default: stateNext = POPA;
                endcase
            end
            POPA: begin
                case (bus.opc)
                    OP_NOT:  stateNext = EXEC;
                    OP_POP:  stateNext = MEMWR;
                    default: stateNext = POPB;
                endcase
            end
            POPB:    stateNext = EXEC;
            EXEC:    stateNext = PUSHR;
            MEMRD:   stateNext = PUSHM;
            default: stateNext = FETCH;
        endcase
    end

    // Outputs are registered alongside the state, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= FETCH;
            ctrlReg  <= FETCH_CTRL;
        end else begin
            stateReg <= stateNext;
            ctrlReg  <= decodeCtrl(stateNext, bus.opc);
        end
    end

    // Gating with rst kills every strobe the instant reset asserts, not at the next edge.
    assign ctrlOut = rst ? ctrlReg : '0;

    assign bus.pcWriteUnCond = ctrlOut.pcWriteUnCond;
    assign bus.pcWriteCond   = ctrlOut.pcWriteCond;
    assign bus.IorD          = ctrlOut.IorD;
    assign bus.memRead       = ctrlOut.memRead;
    assign bus.memWrite      = ctrlOut.memWrite;
    assign bus.IRWrite       = ctrlOut.IRWrite;
    assign bus.MtoS          = ctrlOut.MtoS;
    assign bus.push          = ctrlOut.push;
    assign bus.pop           = ctrlOut.pop;
    assign bus.tos           = ctrlOut.tos;
    assign bus.ldA           = ctrlOut.ldA;
    assign bus.ldB           = ctrlOut.ldB;
    assign bus.srcA          = ctrlOut.srcA;
    assign bus.srcB          = ctrlOut.srcB;
    assign bus.pcSrc         = ctrlOut.pcSrc;
    assign bus.aluOp         = ctrlOut.aluOp;
    assign bus.fetchStart    = ctrlOut.fetchStart;

    // The zero flag gates the PC write inside the datapath; the controller never branches on it.
    logic unused;
    assign unused = bus.zero;

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instrCount <= '0;
            cycleCount <= '0;
        end else begin
            cycleCount <= cycleCount + 16'd1;
            if (stateReg inside {PUSHR, PUSHM, MEMWR, JMP, JZ})
                instrCount <= instrCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stack_cpu_controller.sv
// Self-checking bench for stack_cpu_controller: vector table, random opcode stream,
// and hand-written reset sequences, compared cycle by cycle against an instruction-level model.
module tb_stack_cpu_controller;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    stack_cpu_controller_if bus();

`ifdef INSTR_COUNT_EN
    logic [15:0] instrCount;
    logic [15:0] cycleCount;
`endif

    stack_cpu_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef INSTR_COUNT_EN
        ,
        .instrCount(instrCount),
        .cycleCount(cycleCount)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Bit positions of the packed output word built by sampleOut().
    localparam int B_PCU = 17, B_PCC = 16, B_IORD = 15, B_MRD = 14, B_MWR = 13, B_IRW = 12;
    localparam int B_MTOS = 11, B_PUSH = 10, B_POP = 9, B_TOS = 8, B_LDA = 7, B_LDB = 6;
    localparam int B_SRCA = 5, B_SRCB = 4, B_PCSRC = 3, B_ALU = 1, B_FS = 0;

    localparam logic [17:0] ONE = 18'd1;
    localparam logic [17:0] S_FETCH  = (ONE << B_PCU) | (ONE << B_MRD) | (ONE << B_IRW) | (ONE << B_FS);
    localparam logic [17:0] S_DECODE = ONE << B_TOS;
    localparam logic [17:0] S_POPA   = (ONE << B_POP) | (ONE << B_LDA);
    localparam logic [17:0] S_POPB   = (ONE << B_POP) | (ONE << B_LDB);
    localparam logic [17:0] S_EXEC   = (ONE << B_SRCA) | (ONE << B_SRCB);
    localparam logic [17:0] S_PUSHR  = ONE << B_PUSH;
    localparam logic [17:0] S_MEMRD  = (ONE << B_IORD) | (ONE << B_MRD);
    localparam logic [17:0] S_PUSHM  = (ONE << B_MTOS) | (ONE << B_PUSH);
    localparam logic [17:0] S_MEMWR  = (ONE << B_IORD) | (ONE << B_MWR);
    localparam logic [17:0] S_JMP    = (ONE << B_PCSRC) | (ONE << B_PCU);
    localparam logic [17:0] S_JZ     = (ONE << B_PCSRC) | (ONE << B_PCC);

    logic [17:0] expSteps[$];

    function automatic logic [17:0] sampleOut();
        return {bus.pcWriteUnCond, bus.pcWriteCond, bus.IorD, bus.memRead, bus.memWrite,
                bus.IRWrite, bus.MtoS, bus.push, bus.pop, bus.tos, bus.ldA, bus.ldB,
                bus.srcA, bus.srcB, bus.pcSrc, bus.aluOp, bus.fetchStart};
    endfunction

    // Instruction-level model: the per-cycle micro-steps each opcode class performs.
    function automatic void buildSteps(input logic [2:0] op);
        logic [17:0] ex;
        expSteps = {};
        expSteps.push_back(S_FETCH);
        expSteps.push_back(S_DECODE);
        case (op)
            3'b000: ex = S_EXEC;
            3'b001: ex = S_EXEC | (ONE << B_ALU);
            3'b010: ex = S_EXEC | (ONE << (B_ALU + 1));
            default: ex = S_EXEC | (ONE << B_ALU) | (ONE << (B_ALU + 1));
        endcase
        case (op)
            3'b000, 3'b001, 3'b010: begin
                expSteps.push_back(S_POPA);
                expSteps.push_back(S_POPB);
                expSteps.push_back(ex);
                expSteps.push_back(S_PUSHR);
            end
            3'b011: begin
                expSteps.push_back(S_POPA);
                expSteps.push_back(ex);
                expSteps.push_back(S_PUSHR);
            end
            3'b100: begin
                expSteps.push_back(S_MEMRD);
                expSteps.push_back(S_PUSHM);
            end
            3'b101: begin
                expSteps.push_back(S_POPA);
                expSteps.push_back(S_MEMWR);
            end
            3'b110:  expSteps.push_back(S_JMP);
            default: expSteps.push_back(S_JZ);
        endcase
    endfunction

    task automatic checkVec(input string name, input logic [17:0] got, input logic [17:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%05h want=%05h", name, got, want);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Entered at negedge+1 of a FETCH cycle; returns at negedge+1 of the next FETCH.
    task automatic runInstr(input string tag, input logic [2:0] op, input logic z,
                            output int cycles, output int pops);
        int n;
        logic [17:0] got;
        buildSteps(op);
        n = 0;
        pops = 0;
        while (1) begin
            got = sampleOut();
            checkVec($sformatf("%s op=%0d step%0d", tag, op, n), got,
                     (n < expSteps.size()) ? expSteps[n] : 18'h0);
            if (got[B_POP]) pops++;
            if (n == 0) begin
                bus.opc  = op;
                bus.zero = z;
            end
            @(negedge clk);
            #1;
            n++;
            if (bus.fetchStart === 1'b1 || n >= 16) break;
        end
        cycles = n;
        $display("instr %s op=%0d zero=%0d cycles=%0d pops=%0d", tag, op, z, cycles, pops);
    endtask

    typedef struct {
        logic [2:0] opc;
        logic       zero;
        int         expCycles;
        int         expPops;
    } vecT;

    vecT vecs[9];

    initial begin
        int cyc, pops, instrDone, edgeCount;
        logic [2:0] op;
        logic z;
        checks = 0;
        failures = 0;
        instrDone = 0;
        edgeCount = 0;

        vecs[0] = '{3'b000, 1'b0, 6, 2};
        vecs[1] = '{3'b011, 1'b1, 5, 1};
        vecs[2] = '{3'b001, 1'b0, 6, 2};
        vecs[3] = '{3'b010, 1'b1, 6, 2};
        vecs[4] = '{3'b100, 1'b0, 4, 0};
        vecs[5] = '{3'b101, 1'b0, 4, 1};
        vecs[6] = '{3'b110, 1'b1, 3, 0};
        vecs[7] = '{3'b111, 1'b0, 3, 0};
        vecs[8] = '{3'b111, 1'b1, 3, 0};

        rst = 1'b0;
        bus.opc = 3'b000;
        bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkVec($sformatf("reset cycle%0d", i), sampleOut(), 18'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVec("first after release", sampleOut(), S_FETCH);
`ifdef INSTR_COUNT_EN
        checkInt("instrCount after reset", int'(instrCount), 0);
        checkInt("cycleCount after reset", int'(cycleCount), 0);
`endif

        for (int i = 0; i < 9; i++) begin
            runInstr($sformatf("vec%0d", i), vecs[i].opc, vecs[i].zero, cyc, pops);
            checkInt($sformatf("vec%0d cycles", i), cyc, vecs[i].expCycles);
            checkInt($sformatf("vec%0d pops", i), pops, vecs[i].expPops);
            instrDone++;
            edgeCount += cyc;
        end

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            z  = 1'($urandom_range(0, 1));
            runInstr($sformatf("rnd%0d", i), op, z, cyc, pops);
            checkInt($sformatf("rnd%0d cycles", i), cyc, expSteps.size());
            instrDone++;
            edgeCount += cyc;
        end
`ifdef INSTR_COUNT_EN
        checkInt("instrCount after stream", int'(instrCount), instrDone % 65536);
        checkInt("cycleCount after stream", int'(cycleCount), edgeCount % 65536);
`endif

        // Reset asserted mid-instruction while POPB drives pop/ldB.
        bus.opc = 3'b000;
        checkVec("midreset fetch", sampleOut(), S_FETCH);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
        end
        checkVec("midreset popb", sampleOut(), S_POPB);
        #1;
        rst = 1'b0;
        #1;
        checkVec("midreset async drop", sampleOut(), 18'h0);
        @(negedge clk);
        #1;
        checkVec("midreset held", sampleOut(), 18'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVec("midreset release fetch", sampleOut(), S_FETCH);
`ifdef INSTR_COUNT_EN
        checkInt("instrCount after midreset", int'(instrCount), 0);
        checkInt("cycleCount after midreset", int'(cycleCount), 0);
`endif
        runInstr("post add", 3'b000, 1'b0, cyc, pops);
        checkInt("post add cycles", cyc, 6);
        runInstr("post jmp", 3'b110, 1'b0, cyc, pops);
        checkInt("post jmp cycles", cyc, 3);
`ifdef INSTR_COUNT_EN
        checkInt("instrCount add+jmp", int'(instrCount), 2);
        checkInt("cycleCount add+jmp", int'(cycleCount), 9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
